router_pkt_tx: RTL and testbench

- Packet source that drives the router's input side (pkt_valid / data_in / busy).
- Payload bytes are preloaded into an internal byte buffer. On a start command the block emits one packet: a header byte, then len payload bytes with pkt_valid high, then a parity byte with pkt_valid low.
- Holds the current byte while the router asserts busy, and captures the router's err flag after each packet.

---
 rtl/router_pkt_tx_if.sv | 45 ++++
 rtl/router_pkt_tx.sv | 161 ++++++++++++++++
 tb/tb_router_pkt_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Router packet-source bus: buffer fill, packet command/status and router-side byte stream.
// ROUTER_TX_PARITY_INJ_EN adds inj_parity to the command group.
interface router_pkt_tx_if #(
  parameter int BUF_DEPTH = 64
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          buf_full;
  logic [CW-1:0] buf_count;
  logic          start;
  logic [1:0]    dest_addr;
  logic [5:0]    len;
  logic          tx_idle;
  logic          start_err;
  logic          busy;
  logic          err;
  logic          pkt_valid;
  logic [7:0]    data_out;
  logic          done;
  logic          err_flag;
  logic [15:0]   pkt_count;
`ifdef ROUTER_TX_PARITY_INJ_EN
  logic          inj_parity;

  modport master (
    output wr_en, wr_data, start, dest_addr, len, busy, err, inj_parity,
    input  buf_full, buf_count, tx_idle, start_err, pkt_valid, data_out, done, err_flag, pkt_count
  );
  modport slave (
    input  wr_en, wr_data, start, dest_addr, len, busy, err, inj_parity,
    output buf_full, buf_count, tx_idle, start_err, pkt_valid, data_out, done, err_flag, pkt_count
  );
`else
  modport master (
    output wr_en, wr_data, start, dest_addr, len, busy, err,
    input  buf_full, buf_count, tx_idle, start_err, pkt_valid, data_out, done, err_flag, pkt_count
  );
  modport slave (
    input  wr_en, wr_data, start, dest_addr, len, busy, err,
    output buf_full, buf_count, tx_idle, start_err, pkt_valid, data_out, done, err_flag, pkt_count
  );
`endif
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for the router input: header, buffered payload, then parity byte.
// Optional ROUTER_TX_PARITY_INJ_EN: flip parity bit 0 on request to provoke router err.
module router_pkt_tx #(
  parameter int BUF_DEPTH  = 64,
  parameter int IFG_CYCLES = 2
) (
  input  logic           router_clock,
  input  logic           resetn,
  router_pkt_tx_if.slave bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, GAP} state_t;

  logic [7:0]    mem [BUF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;
  logic [7:0]    pop_data, hdr_byte;

  state_t        state, state_n;
  logic          accept, reject, consume, start_ok;
  logic [5:0]    remaining;
  logic [7:0]    parity;
  logic [GW-1:0] gap_cnt;
  logic          inj_q;

  logic [7:0]    data_q;
  logic          valid_q, done_q, start_err_q, err_flag_q;
  logic [15:0]   pkt_count_q;

  assign full     = (count == CW'(BUF_DEPTH));
  assign push     = bus.wr_en && !full;
  assign pop_data = mem[rd_ptr];
  assign hdr_byte = {bus.len, bus.dest_addr};
  assign start_ok = (bus.dest_addr != 2'd3) && (bus.len != 6'd0) && (CW'(bus.len) <= count);

  // Payload buffer: storage needs no reset, only the pointers/count do.
  always_ff @(posedge router_clock)
    if (push) mem[wr_ptr] <= bus.wr_data;

  always_ff @(posedge router_clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge router_clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    pop     = 1'b0;
    consume = !bus.busy && (state == HDR || state == PAY || state == PAR);
    case (state)
      IDLE: if (bus.start) begin
        if (start_ok) begin
          accept  = 1'b1;
          state_n = HDR;
        end else begin
          reject  = 1'b1;
        end
      end
      HDR: if (consume) begin
        pop     = 1'b1;
        state_n = PAY;
      end
      PAY: if (consume) begin
        if (remaining > 6'd1) pop = 1'b1;
        else                  state_n = PAR;
      end
      PAR: if (consume) state_n = GAP;
      GAP: if (gap_cnt == GW'(IFG_CYCLES - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef ROUTER_TX_PARITY_INJ_EN
  always_ff @(posedge router_clock or negedge resetn) begin
    if (!resetn)     inj_q <= 1'b0;
    else if (accept) inj_q <= bus.inj_parity;
  end
`else
  assign inj_q = 1'b0;
`endif

  always_ff @(posedge router_clock or negedge resetn) begin
    if (!resetn) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      err_flag_q  <= 1'b0;
      pkt_count_q <= '0;
      parity      <= '0;
      remaining   <= '0;
      gap_cnt     <= '0;
    end else begin
      start_err_q <= reject;
      done_q      <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          data_q     <= hdr_byte;
          valid_q    <= 1'b1;
          err_flag_q <= 1'b0;
          parity     <= hdr_byte;
          remaining  <= bus.len;
        end
        HDR: if (consume) data_q <= pop_data;
        PAY: if (consume) begin
          parity    <= parity ^ data_q;
          remaining <= remaining - 6'd1;
          // Last payload byte: fold it into the parity that goes out next.
          if (pop) begin
            data_q  <= pop_data;
          end else begin
            data_q  <= parity ^ data_q ^ {7'd0, inj_q};
            valid_q <= 1'b0;
          end
        end
        PAR: if (consume) begin
          data_q      <= '0;
          done_q      <= 1'b1;
          pkt_count_q <= pkt_count_q + 16'd1;
          gap_cnt     <= '0;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (bus.err) err_flag_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.buf_full  = full;
  assign bus.buf_count = count;
  assign bus.tx_idle   = (state == IDLE);
  assign bus.start_err = start_err_q;
  assign bus.pkt_valid = valid_q;
  assign bus.data_out  = data_q;
  assign bus.done      = done_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.pkt_count = pkt_count_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: byte sequences, stalls, rejects, buffer limits, err capture, reset.
module tb_router_pkt_tx;
  logic router_clock = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_pkts = 0;

  router_pkt_tx_if #(.BUF_DEPTH(64)) bus ();
  router_pkt_tx #(.BUF_DEPTH(64), .IFG_CYCLES(2)) dut (
    .router_clock(router_clock),
    .resetn      (resetn),
    .bus         (bus)
  );

  always #5 router_clock = ~router_clock;

  task automatic tick;
    @(posedge router_clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.wr_en = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic send_start(input logic [1:0] d, input logic [5:0] l);
    bus.start = 1'b1;
    bus.dest_addr = d;
    bus.len = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) tick();
    checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid got=%0h exp=0", bus.pkt_valid); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%0h exp=0", bus.data_out); end
    checks++; if (bus.done !== 1'b0 || bus.start_err !== 1'b0 || bus.err_flag !== 1'b0) begin errors++; $display("FAIL reset_pulses got done=%0h start_err=%0h err_flag=%0h exp=0", bus.done, bus.start_err, bus.err_flag); end
    checks++; if (bus.pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count got=%0d exp=0", bus.pkt_count); end
    checks++; if (bus.buf_count !== 7'd0 || bus.buf_full !== 1'b0) begin errors++; $display("FAIL reset_buf got count=%0d full=%0h exp=0/0", bus.buf_count, bus.buf_full); end
    checks++; if (bus.tx_idle !== 1'b1) begin errors++; $display("FAIL reset_tx_idle got=%0h exp=1", bus.tx_idle); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [7:0] exp_d [6] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    checks++; if (bus.buf_count !== 7'd4) begin errors++; $display("FAIL basic_fill got=%0d exp=4", bus.buf_count); end
    send_start(2'd1, 6'd4);
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.data_out !== exp_d[i]) begin errors++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, bus.data_out, exp_d[i]); end
      checks++; if (bus.pkt_valid !== (i < 5)) begin errors++; $display("FAIL basic_valid[%0d] got=%0h exp=%0h", i, bus.pkt_valid, (i < 5)); end
      tick();
    end
    exp_pkts++;
    checks++; if (bus.done !== 1'b1 || bus.data_out !== 8'h00) begin errors++; $display("FAIL basic_done got done=%0h data=%0h exp=1/0", bus.done, bus.data_out); end
    checks++; if (bus.pkt_count !== 16'(exp_pkts) || bus.buf_count !== 7'd0) begin errors++; $display("FAIL basic_counts got pkt=%0d buf=%0d exp=%0d/0", bus.pkt_count, bus.buf_count, exp_pkts); end
    checks++; if (bus.tx_idle !== 1'b0) begin errors++; $display("FAIL basic_gap_busy got=%0h exp=0", bus.tx_idle); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.tx_idle !== 1'b0) begin errors++; $display("FAIL basic_gap2 got done=%0h idle=%0h exp=0/0", bus.done, bus.tx_idle); end
    tick();
    checks++; if (bus.tx_idle !== 1'b1) begin errors++; $display("FAIL basic_back_idle got=%0h exp=1", bus.tx_idle); end
  endtask

  task automatic test_busy_stall;
    logic [7:0] exp_d [6] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    send_start(2'd1, 6'd4);
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.data_out !== exp_d[i] || bus.pkt_valid !== (i < 5)) begin errors++; $display("FAIL stall_seq[%0d] got=%0h/%0h exp=%0h/%0h", i, bus.data_out, bus.pkt_valid, exp_d[i], (i < 5)); end
      if (i == 2) begin
        bus.busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          checks++; if (bus.data_out !== 8'h22 || bus.pkt_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got=%0h/%0h exp=22/1", k, bus.data_out, bus.pkt_valid); end
        end
        bus.busy = 1'b0;
      end
      tick();
    end
    exp_pkts++;
    checks++; if (bus.done !== 1'b1 || bus.pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL stall_done got done=%0h pkt=%0d exp=1/%0d", bus.done, bus.pkt_count, exp_pkts); end
    repeat (2) tick();
  endtask

  task automatic test_rejects;
    logic [1:0] d [3] = '{2'd3, 2'd1, 2'd1};
    logic [5:0] l [3] = '{6'd4, 6'd0, 6'd5};
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    for (int i = 0; i < 3; i++) begin
      send_start(d[i], l[i]);
      checks++; if (bus.start_err !== 1'b1) begin errors++; $display("FAIL reject_err[%0d] got=%0h exp=1", i, bus.start_err); end
      checks++; if (bus.tx_idle !== 1'b1 || bus.pkt_valid !== 1'b0 || bus.buf_count !== 7'd4) begin errors++; $display("FAIL reject_state[%0d] got idle=%0h valid=%0h buf=%0d exp=1/0/4", i, bus.tx_idle, bus.pkt_valid, bus.buf_count); end
      tick();
      checks++; if (bus.start_err !== 1'b0) begin errors++; $display("FAIL reject_pulse[%0d] got=%0h exp=0", i, bus.start_err); end
    end
  endtask

  task automatic test_router_err;
    logic [7:0] exp_d [6] = '{8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h14};
    send_start(2'd0, 6'd4);
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.data_out !== exp_d[i] || bus.start_err !== 1'b0) begin errors++; $display("FAIL err_seq[%0d] got=%0h start_err=%0h exp=%0h/0", i, bus.data_out, bus.start_err, exp_d[i]); end
      // an illegal start while busy must be ignored silently
      if (i == 1) begin bus.start = 1'b1; bus.dest_addr = 2'd3; bus.len = 6'd0; end
      if (i == 5) bus.start = 1'b0;
      tick();
    end
    exp_pkts++;
    bus.err = 1'b1;
    tick();
    bus.err = 1'b0;
    checks++; if (bus.err_flag !== 1'b1) begin errors++; $display("FAIL err_capture got=%0h exp=1", bus.err_flag); end
    repeat (2) tick();
    checks++; if (bus.err_flag !== 1'b1 || bus.tx_idle !== 1'b1) begin errors++; $display("FAIL err_sticky got flag=%0h idle=%0h exp=1/1", bus.err_flag, bus.tx_idle); end
    checks++; if (bus.pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL err_pkt_count got=%0d exp=%0d", bus.pkt_count, exp_pkts); end
    push_byte(8'h5A);
    send_start(2'd0, 6'd1);
    bus.err = 1'b1;
    checks++; if (bus.err_flag !== 1'b0 || bus.data_out !== 8'h04) begin errors++; $display("FAIL err_clear got flag=%0h data=%0h exp=0/04", bus.err_flag, bus.data_out); end
    tick();
    checks++; if (bus.data_out !== 8'h5A) begin errors++; $display("FAIL err_len1_pay got=%0h exp=5a", bus.data_out); end
    tick();
    bus.err = 1'b0;
    checks++; if (bus.data_out !== 8'h5E || bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL err_len1_par got=%0h/%0h exp=5e/0", bus.data_out, bus.pkt_valid); end
    tick();
    exp_pkts++;
    checks++; if (bus.err_flag !== 1'b0 || bus.done !== 1'b1) begin errors++; $display("FAIL err_ignored got flag=%0h done=%0h exp=0/1", bus.err_flag, bus.done); end
    repeat (2) tick();
  endtask

  task automatic test_buf_full;
    for (int i = 0; i < 65; i++) push_byte(8'(i));
    checks++; if (bus.buf_full !== 1'b1 || bus.buf_count !== 7'd64) begin errors++; $display("FAIL full_level got full=%0h count=%0d exp=1/64", bus.buf_full, bus.buf_count); end
    send_start(2'd2, 6'd63);
    checks++; if (bus.data_out !== 8'hFE || bus.pkt_valid !== 1'b1) begin errors++; $display("FAIL full_hdr got=%0h/%0h exp=fe/1", bus.data_out, bus.pkt_valid); end
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hC0;
    for (int i = 0; i < 63; i++) begin
      tick();
      checks++; if (bus.data_out !== 8'(i) || bus.pkt_valid !== 1'b1 || bus.buf_count !== 7'd63) begin errors++; $display("FAIL full_pay[%0d] got=%0h/%0h count=%0d exp=%0h/1/63", i, bus.data_out, bus.pkt_valid, bus.buf_count, i); end
      bus.wr_data = bus.wr_data + 8'd1;
    end
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.data_out !== 8'hC1 || bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL full_par got=%0h/%0h exp=c1/0", bus.data_out, bus.pkt_valid); end
    checks++; if (bus.buf_count !== 7'd64 || bus.buf_full !== 1'b1) begin errors++; $display("FAIL full_refill got count=%0d full=%0h exp=64/1", bus.buf_count, bus.buf_full); end
    tick();
    exp_pkts++;
    checks++; if (bus.done !== 1'b1 || bus.pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL full_done got done=%0h pkt=%0d exp=1/%0d", bus.done, bus.pkt_count, exp_pkts); end
    repeat (2) tick();
    send_start(2'd0, 6'd2);
    checks++; if (bus.data_out !== 8'h08) begin errors++; $display("FAIL wrap_hdr got=%0h exp=08", bus.data_out); end
    tick();
    checks++; if (bus.data_out !== 8'h3F) begin errors++; $display("FAIL wrap_old got=%0h exp=3f", bus.data_out); end
    tick();
    checks++; if (bus.data_out !== 8'hC1) begin errors++; $display("FAIL wrap_new got=%0h exp=c1", bus.data_out); end
    tick();
    checks++; if (bus.data_out !== 8'hF6 || bus.buf_count !== 7'd62) begin errors++; $display("FAIL wrap_par got=%0h count=%0d exp=f6/62", bus.data_out, bus.buf_count); end
    tick();
    exp_pkts++;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_d [6] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_start(2'd1, 6'd4);
    repeat (2) tick();
    checks++; if (bus.data_out !== 8'hC3) begin errors++; $display("FAIL rst_pre got=%0h exp=c3", bus.data_out); end
    resetn = 1'b0;
    #1;
    checks++; if (bus.pkt_valid !== 1'b0 || bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_out got=%0h/%0h exp=0/0", bus.pkt_valid, bus.data_out); end
    checks++; if (bus.buf_count !== 7'd0 || bus.tx_idle !== 1'b1 || bus.pkt_count !== 16'd0) begin errors++; $display("FAIL rst_state got buf=%0d idle=%0h pkt=%0d exp=0/1/0", bus.buf_count, bus.tx_idle, bus.pkt_count); end
    tick();
    resetn = 1'b1;
    tick();
    exp_pkts = 0;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    send_start(2'd1, 6'd4);
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.data_out !== exp_d[i] || bus.pkt_valid !== (i < 5)) begin errors++; $display("FAIL rst_after[%0d] got=%0h/%0h exp=%0h/%0h", i, bus.data_out, bus.pkt_valid, exp_d[i], (i < 5)); end
      tick();
    end
    exp_pkts++;
    checks++; if (bus.done !== 1'b1 || bus.pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL rst_after_done got done=%0h pkt=%0d exp=1/%0d", bus.done, bus.pkt_count, exp_pkts); end
    repeat (2) tick();
  endtask

`ifdef ROUTER_TX_PARITY_INJ_EN
  task automatic test_parity_inj;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    bus.inj_parity = 1'b1;
    send_start(2'd1, 6'd4);
    bus.inj_parity = 1'b0;
    repeat (5) tick();
    checks++; if (bus.data_out !== 8'h54 || bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL inj_parity got=%0h/%0h exp=54/0", bus.data_out, bus.pkt_valid); end
    repeat (3) tick();
  endtask
`endif

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.start = 1'b0; bus.dest_addr = '0;
    bus.len = '0; bus.busy = 1'b0; bus.err = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
    bus.inj_parity = 1'b0;
`endif
    test_reset();
    test_basic();
    test_busy_stall();
    test_rejects();
    test_router_err();
    test_buf_full();
    test_reset_mid();
`ifdef ROUTER_TX_PARITY_INJ_EN
    test_parity_inj();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
